key_board: RTL and testbench

Alarm-time adjustment controller for the digital clock. Holds a 4-digit BCD time (HH:MM) that is loaded from the clock core and edited with three debounced push-buttons: adjust/increment, digit select, and confirm. A confirmed value is emitted with a one-cycle valid strobe. The block sits downstream of three `key_filter` debouncers and upstream of the alarm compare/display logic.

---
 rtl/key_board_pkg.sv | 35 +++
 rtl/key_board_bcd_digit_inc.sv | 29 ++
 rtl/key_board.sv | 87 ++++++++
 tb/tb_key_board.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/key_board_pkg.sv
// Shared constants for the alarm-time editor: FSM encoding, digit indices,
// per-digit BCD maxima and the key active level.
package key_board_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StAdjust = 1'b1
  } state_e;

  // Digit index within {H1,H0,M1,M0}
  localparam logic [1:0] DigM0 = 2'd0;
  localparam logic [1:0] DigM1 = 2'd1;
  localparam logic [1:0] DigH0 = 2'd2;
  localparam logic [1:0] DigH1 = 2'd3;

  localparam logic [3:0] MaxM0     = 4'd9;
  localparam logic [3:0] MaxM1     = 4'd5;
  localparam logic [3:0] MaxH0     = 4'd9;
  localparam logic [3:0] MaxH0Late = 4'd3;  // H0 ceiling once H1 == 2
  localparam logic [3:0] MaxH1     = 4'd2;

  localparam logic KeyActive = 1'b0;

  function automatic logic [3:0] digit_max(input logic [1:0] sel, input logic [3:0] h1);
    logic [3:0] max;
    case (sel)
      DigM0:   max = MaxM0;
      DigM1:   max = MaxM1;
      DigH0:   max = (h1 == MaxH1) ? MaxH0Late : MaxH0;
      default: max = MaxH1;
    endcase
    return max;
  endfunction

endpackage

// File: rtl/key_board_bcd_digit_inc.sv
// Increments one selected BCD digit of an HH:MM word with wrap to zero,
// clamping H0 to 3 when H1 rolls up to 2.
module bcd_digit_inc
  import key_board_pkg::*;
(
  input  logic [15:0] bcd_i,
  input  logic [1:0]  sel_i,
  output logic [15:0] bcd_o
);

  logic [3:0] idx;
  logic [3:0] digit;
  logic [3:0] max;
  logic [3:0] inc;

  always_comb begin
    idx   = {sel_i, 2'b00};
    digit = bcd_i[idx +: 4];
    max   = digit_max(sel_i, bcd_i[15:12]);
    // Out-of-range (including non-BCD) digits restart at zero
    inc   = (digit >= max) ? 4'd0 : digit + 4'd1;
    bcd_o = bcd_i;
    bcd_o[idx +: 4] = inc;
    if ((sel_i == DigH1) && (inc == MaxH1) && (bcd_i[11:8] > MaxH0Late)) begin
      bcd_o[11:8] = MaxH0Late;
    end
  end

endmodule

// File: rtl/key_board.sv
// Alarm-time editor: loads HH:MM from the clock core, edits it digit by digit
// from three debounced keys and strobes the confirmed value.
module key_board
  import key_board_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        key_p_state,
  input  logic        key_p_flag,
  input  logic        key_n_state,
  input  logic        key_n_flag,
  input  logic        key_e_state,
  input  logic        key_e_flag,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_out_vld
);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] work_q, work_d;
  logic        vld_q, vld_d;
  logic [15:0] work_inc;
  logic        p_press, n_press, e_press;

  assign p_press = key_p_flag & (key_p_state == KeyActive) & en;
  assign n_press = key_n_flag & (key_n_state == KeyActive) & en;
  assign e_press = key_e_flag & (key_e_state == KeyActive) & en;

  bcd_digit_inc u_inc (
    .bcd_i (work_q),
    .sel_i (sel_q),
    .bcd_o (work_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= DigM0;
      work_q  <= 16'h0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    work_d  = work_q;
    vld_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          work_d = data_in;
        end
        if (p_press) begin
          state_d = StAdjust;
          sel_d   = DigM0;
        end
      end
      StAdjust: begin
        // One action per cycle: confirm beats select beats increment
        if (e_press) begin
          vld_d   = 1'b1;
          state_d = StIdle;
        end else if (n_press) begin
          sel_d = sel_q + 2'd1;
        end else if (p_press) begin
          work_d = work_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_out     = work_q;
    data_out_vld = vld_q;
  end

endmodule

// File: tb/tb_key_board.sv
// Directed bench for key_board: loads, digit edits, wraps, clamps, ignored
// events, key priority and asynchronous reset.
module tb_key_board;

  logic        clk;
  logic        rst;
  logic        load;
  logic        en;
  logic        key_p_state, key_p_flag;
  logic        key_n_state, key_n_flag;
  logic        key_e_state, key_e_flag;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_out_vld;

  int checks;
  int errors;

  key_board dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .en           (en),
    .key_p_state  (key_p_state),
    .key_p_flag   (key_p_flag),
    .key_n_state  (key_n_state),
    .key_n_flag   (key_n_flag),
    .key_e_state  (key_e_state),
    .key_e_flag   (key_e_flag),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_out_vld (data_out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle flag pulse; returns on the falling edge after the capturing edge.
  task automatic press(input logic p, input logic n, input logic e,
                       input logic lvl, input logic en_v);
    @(negedge clk);
    key_p_flag = p; key_n_flag = n; key_e_flag = e;
    key_p_state = p ? lvl : 1'b1;
    key_n_state = n ? lvl : 1'b1;
    key_e_state = e ? lvl : 1'b1;
    en = en_v;
    @(negedge clk);
    key_p_flag = 1'b0; key_n_flag = 1'b0; key_e_flag = 1'b0;
    key_p_state = 1'b1; key_n_state = 1'b1; key_e_state = 1'b1;
    en = 1'b1;
  endtask

  task automatic p_key();
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic n_key();
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic e_key();
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic en_v);
    @(negedge clk);
    load = 1'b1; data_in = v; en = en_v;
    @(negedge clk);
    load = 1'b0; data_in = 16'h0000; en = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    load = 1'b0; en = 1'b1; data_in = 16'h0000;
    key_p_flag = 1'b0; key_n_flag = 1'b0; key_e_flag = 1'b0;
    key_p_state = 1'b1; key_n_state = 1'b1; key_e_state = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_data", data_out, 16'h0000);
    check("reset_vld", {15'd0, data_out_vld}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    do_load(16'h1223, 1'b1);
    check("load_1223", data_out, 16'h1223);
    check("load_vld", {15'd0, data_out_vld}, 16'h0000);

    p_key();
    check("enter_adjust", data_out, 16'h1223);
    p_key();
    check("inc_m0", data_out, 16'h1224);
    n_key();
    check("sel_m1", data_out, 16'h1224);
    p_key();
    check("inc_m1_a", data_out, 16'h1234);
    p_key();
    check("inc_m1_b", data_out, 16'h1244);
    e_key();
    check("confirm_data", data_out, 16'h1244);
    check("confirm_vld", {15'd0, data_out_vld}, 16'h0001);
    @(negedge clk);
    check("confirm_vld_once", {15'd0, data_out_vld}, 16'h0000);

    // Load only succeeds in IDLE, so this also proves the return to IDLE
    do_load(16'h1959, 1'b1);
    check("load_1959", data_out, 16'h1959);
    p_key();
    p_key();
    check("m0_wrap", data_out, 16'h1950);
    n_key();
    p_key();
    check("m1_wrap", data_out, 16'h1900);
    e_key();

    do_load(16'h1923, 1'b1);
    p_key();
    n_key(); n_key(); n_key();
    p_key();
    check("h1_clamp", data_out, 16'h2323);
    p_key();
    check("h1_wrap", data_out, 16'h0323);

    // Ignored events while in ADJUST with sel = H1
    press(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("release_edge", data_out, 16'h0323);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("en_low_p", data_out, 16'h0323);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    p_key();
    check("en_low_sel_frozen", data_out, 16'h1323);
    do_load(16'h5555, 1'b1);
    check("load_in_adjust", data_out, 16'h1323);
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("en_low_e_vld", {15'd0, data_out_vld}, 16'h0000);
    do_load(16'h0000, 1'b1);
    check("still_adjust", data_out, 16'h1323);

    press(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("e_over_p_data", data_out, 16'h1323);
    check("e_over_p_vld", {15'd0, data_out_vld}, 16'h0001);
    @(negedge clk);
    check("e_over_p_vld_once", {15'd0, data_out_vld}, 16'h0000);

    // Load with en low still works in IDLE
    do_load(16'h003C, 1'b0);
    check("load_en_low", data_out, 16'h003C);
    p_key();
    p_key();
    check("non_bcd_inc", data_out, 16'h0030);
    n_key();
    p_key();
    check("m1_inc_after", data_out, 16'h0040);

    // Asynchronous reset in the middle of an edit
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", data_out, 16'h0000);
    check("async_rst_vld", {15'd0, data_out_vld}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    p_key();
    check("post_rst_idle", data_out, 16'h0000);
    p_key();
    check("post_rst_sel_m0", data_out, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
